// File: rtl/riscv_decode_stage.sv
// RV32/64 decode stage: one-cycle latency from accept to out_valid, fully decoded fields.
// Backpressure: output register plus one skid entry; in_ready is registered and drops only while the skid entry is full.
module riscv_decode_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_instr,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [2:0]      out_fmt,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_funct3,
  output logic [XLEN-1:0] out_imm,
  output logic [3:0]      out_alu_op,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_branch,
  output logic            out_jump,
  output logic            out_illegal
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_XOR = 4'b1100;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] STORE_MAX_F3 = (XLEN == 64) ? 3'b011 : 3'b010;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [2:0]      fmt;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu_op;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            illegal;
  } dec_t;

  dec_t        dec;
  dec_t        out_q;
  dec_t        skid_q;
  logic        out_valid_q;
  logic        skid_valid;
  logic        in_ready_q;
  logic        accept;
  logic        advance;
  logic        skid_load;
  logic        skid_keep;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        legal;
  logic        f3_ok;
  logic [3:0]  f3_op;
  logic [31:0] imm32;

  assign opcode = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];

  // funct3 to ALU op for OP/IMM; unsupported funct3 values are illegal there
  always_comb begin
    f3_ok = 1'b1;
    f3_op = ALU_ADD;
    case (f3)
      3'b000:  f3_op = ALU_ADD;
      3'b111:  f3_op = ALU_AND;
      3'b110:  f3_op = ALU_OR;
      3'b100:  f3_op = ALU_XOR;
      3'b010:  f3_op = ALU_SLT;
      default: f3_ok = 1'b0;
    endcase
  end

  always_comb begin
    dec    = '0;
    legal  = 1'b0;
    imm32  = '0;
    dec.pc = in_pc;
    dec.funct3 = f3;
    dec.alu_op = ALU_ADD;
    dec.fmt    = FMT_ILL;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        legal = 1'b1; dec.fmt = FMT_U; dec.reg_write = 1'b1;
      end
      OPC_JAL: begin
        legal = 1'b1; dec.fmt = FMT_J; dec.reg_write = 1'b1; dec.jump = 1'b1;
      end
      OPC_JALR: begin
        legal = (f3 == 3'b000); dec.fmt = FMT_I; dec.reg_write = 1'b1; dec.jump = 1'b1;
      end
      OPC_BRANCH: begin
        legal = (f3 != 3'b010) && (f3 != 3'b011);
        dec.fmt = FMT_B; dec.alu_op = ALU_SUB; dec.branch = 1'b1;
      end
      OPC_LOAD: begin
        legal = !((f3 == 3'b011) && (XLEN == 32)) && (f3 != 3'b110) && (f3 != 3'b111);
        dec.fmt = FMT_I; dec.reg_write = 1'b1; dec.mem_read = 1'b1;
      end
      OPC_STORE: begin
        legal = (f3 <= STORE_MAX_F3); dec.fmt = FMT_S; dec.mem_write = 1'b1;
      end
      OPC_IMM: begin
        legal = f3_ok; dec.fmt = FMT_I; dec.alu_op = f3_op; dec.reg_write = 1'b1;
      end
      OPC_OP: begin
        dec.fmt = FMT_R; dec.reg_write = 1'b1;
        if (f7 == 7'b0000000) begin
          legal = f3_ok; dec.alu_op = f3_op;
        end else if (f7 == 7'b0100000) begin
          legal = (f3 == 3'b000); dec.alu_op = ALU_SUB;
        end
      end
      default: legal = 1'b0;
    endcase

    if (in_instr[1:0] != 2'b11) legal = 1'b0;

    if (!legal) begin
      dec.fmt       = FMT_ILL;
      dec.alu_op    = ALU_ADD;
      dec.reg_write = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.branch    = 1'b0;
      dec.jump      = 1'b0;
      dec.illegal   = 1'b1;
    end

    case (dec.fmt)
      FMT_I:   imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S:   imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B:   imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                        in_instr[11:8], 1'b0};
      FMT_U:   imm32 = {in_instr[31:12], 12'b0};
      FMT_J:   imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                        in_instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    dec.imm = {{(XLEN-31){imm32[31]}}, imm32[30:0]};

    dec.rs1 = (dec.fmt == FMT_U || dec.fmt == FMT_J) ? 5'd0 : in_instr[19:15];
    dec.rs2 = (dec.fmt == FMT_R || dec.fmt == FMT_S || dec.fmt == FMT_B) ? in_instr[24:20] : 5'd0;
    dec.rd  = (dec.fmt == FMT_S || dec.fmt == FMT_B) ? 5'd0 : in_instr[11:7];
  end

  assign accept    = in_valid && in_ready_q;
  assign advance   = !out_valid_q || out_ready;
  assign skid_load = !advance && accept;
  assign skid_keep = !advance && skid_valid;

  // skid only fills when the output is stalled, so it always holds the younger entry
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      out_q.pc    <= RESET_PC;
      out_valid_q <= 1'b0;
      skid_q      <= '0;
      skid_valid  <= 1'b0;
      in_ready_q  <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      skid_valid  <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      in_ready_q <= !(skid_load || skid_keep);
      if (advance) begin
        if (skid_valid) begin
          out_q       <= skid_q;
          out_valid_q <= 1'b1;
          skid_valid  <= 1'b0;
        end else if (accept) begin
          out_q       <= dec;
          out_valid_q <= 1'b1;
        end else begin
          out_valid_q <= 1'b0;
        end
      end else if (accept) begin
        skid_q     <= dec;
        skid_valid <= 1'b1;
      end
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_pc        = out_q.pc;
  assign out_fmt       = out_q.fmt;
  assign out_rs1       = out_q.rs1;
  assign out_rs2       = out_q.rs2;
  assign out_rd        = out_q.rd;
  assign out_funct3    = out_q.funct3;
  assign out_imm       = out_q.imm;
  assign out_alu_op    = out_q.alu_op;
  assign out_reg_write = out_q.reg_write;
  assign out_mem_read  = out_q.mem_read;
  assign out_mem_write = out_q.mem_write;
  assign out_branch    = out_q.branch;
  assign out_jump      = out_q.jump;
  assign out_illegal   = out_q.illegal;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Directed vector bench for riscv_decode_stage: decode table plus skid, flush and reset sequences.
module tb_riscv_decode_stage;

  localparam logic [31:0] RPC = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [2:0]  out_fmt;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [2:0]  out_funct3;
  logic [31:0] out_imm;
  logic [3:0]  out_alu_op;
  logic        out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump;
  logic        out_illegal;

  logic        w_in_ready, w_out_valid;
  logic [63:0] w_out_pc, w_out_imm;
  logic [2:0]  w_out_fmt, w_out_funct3;
  logic [4:0]  w_out_rs1, w_out_rs2, w_out_rd;
  logic [3:0]  w_out_alu_op;
  logic        w_rw, w_mr, w_mw, w_br, w_jp, w_ill;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  riscv_decode_stage #(.XLEN(32), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_fmt(out_fmt), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_funct3(out_funct3), .out_imm(out_imm), .out_alu_op(out_alu_op),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_branch(out_branch), .out_jump(out_jump),
    .out_illegal(out_illegal)
  );

  riscv_decode_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_pc({32'b0, in_pc}), .in_instr(in_instr), .flush(flush),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_pc(w_out_pc),
    .out_fmt(w_out_fmt), .out_rs1(w_out_rs1), .out_rs2(w_out_rs2), .out_rd(w_out_rd),
    .out_funct3(w_out_funct3), .out_imm(w_out_imm), .out_alu_op(w_out_alu_op),
    .out_reg_write(w_rw), .out_mem_read(w_mr), .out_mem_write(w_mw),
    .out_branch(w_br), .out_jump(w_jp), .out_illegal(w_ill)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  fmt;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [4:0]  strb;   // {reg_write, mem_read, mem_write, branch, jump}
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic [31:0] instr, logic [31:0] pc, logic [2:0] fmt,
                              logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                              logic [31:0] imm, logic [3:0] alu, logic [4:0] strb, logic ill);
    vec_t v;
    v.name = n; v.instr = instr; v.pc = pc; v.fmt = fmt;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.imm = imm;
    v.alu = alu; v.strb = strb; v.ill = ill;
    return v;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(logic v, logic [31:0] instr, logic [31:0] pc);
    in_valid = v;
    in_instr = instr;
    in_pc    = pc;
  endtask

  initial begin
    logic [2:0]  f3_exp;
    logic [63:0] imm64_exp;

    vecs.push_back(mk("addi",     32'hFFF08293, 32'h100, 3'd1, 5'd1, 5'd0, 5'd5, 32'hFFFFFFFF, 4'b0010, 5'b10000, 1'b0));
    vecs.push_back(mk("beq",      32'hFE000EE3, 32'h104, 3'd3, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 4'b0110, 5'b00010, 1'b0));
    vecs.push_back(mk("lui",      32'h123450B7, 32'h108, 3'd4, 5'd0, 5'd0, 5'd1, 32'h12345000, 4'b0010, 5'b10000, 1'b0));
    vecs.push_back(mk("zero",     32'h00000000, 32'h10C, 3'd7, 5'd0, 5'd0, 5'd0, 32'h00000000, 4'b0010, 5'b00000, 1'b1));
    vecs.push_back(mk("f7sub_f3", 32'h40001033, 32'h110, 3'd7, 5'd0, 5'd0, 5'd0, 32'h00000000, 4'b0010, 5'b00000, 1'b1));
    vecs.push_back(mk("add",      32'h002081B3, 32'h114, 3'd0, 5'd1, 5'd2, 5'd3, 32'h00000000, 4'b0010, 5'b10000, 1'b0));
    vecs.push_back(mk("sub",      32'h402081B3, 32'h118, 3'd0, 5'd1, 5'd2, 5'd3, 32'h00000000, 4'b0110, 5'b10000, 1'b0));
    vecs.push_back(mk("xor",      32'h0020C233, 32'h11C, 3'd0, 5'd1, 5'd2, 5'd4, 32'h00000000, 4'b1100, 5'b10000, 1'b0));
    vecs.push_back(mk("sw",       32'h0020A423, 32'h120, 3'd2, 5'd1, 5'd2, 5'd0, 32'h00000008, 4'b0010, 5'b00100, 1'b0));
    vecs.push_back(mk("lw",       32'hFFC0A283, 32'h124, 3'd1, 5'd1, 5'd0, 5'd5, 32'hFFFFFFFC, 4'b0010, 5'b11000, 1'b0));
    vecs.push_back(mk("jal",      32'hFF9FF0EF, 32'h128, 3'd5, 5'd0, 5'd0, 5'd1, 32'hFFFFFFF8, 4'b0010, 5'b10001, 1'b0));
    vecs.push_back(mk("jalr",     32'h00008067, 32'h12C, 3'd1, 5'd1, 5'd0, 5'd0, 32'h00000000, 4'b0010, 5'b10001, 1'b0));
    vecs.push_back(mk("jalr_f3",  32'h00009067, 32'h130, 3'd7, 5'd1, 5'd0, 5'd0, 32'h00000000, 4'b0010, 5'b00000, 1'b1));
    vecs.push_back(mk("slti",     32'h00512093, 32'h134, 3'd1, 5'd2, 5'd0, 5'd1, 32'h00000005, 4'b0111, 5'b10000, 1'b0));
    vecs.push_back(mk("br_f3_2",  32'h00002063, 32'h138, 3'd7, 5'd0, 5'd0, 5'd0, 32'h00000000, 4'b0010, 5'b00000, 1'b1));
    vecs.push_back(mk("lui_neg",  32'h800000B7, 32'h13C, 3'd4, 5'd0, 5'd0, 5'd1, 32'h80000000, 4'b0010, 5'b10000, 1'b0));

    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);

    // reset state
    repeat (2) @(negedge clk);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.in_ready",  64'(in_ready),  64'd0);
    check("rst.out_pc",    64'(out_pc),    64'(RPC));
    check("rst.out_imm",   64'(out_imm),   64'd0);
    check("rst.out_fmt",   64'(out_fmt),   64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst.in_ready", 64'(in_ready), 64'd1);

    // back-to-back decode table with the consumer always ready
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].instr, vecs[i].pc);
      f3_exp    = vecs[i].instr[14:12];
      imm64_exp = {{32{vecs[i].imm[31]}}, vecs[i].imm};
      @(negedge clk);
      check({vecs[i].name, ".valid"},  64'(out_valid),  64'd1);
      check({vecs[i].name, ".pc"},     64'(out_pc),     64'(vecs[i].pc));
      check({vecs[i].name, ".fmt"},    64'(out_fmt),    64'(vecs[i].fmt));
      check({vecs[i].name, ".rs1"},    64'(out_rs1),    64'(vecs[i].rs1));
      check({vecs[i].name, ".rs2"},    64'(out_rs2),    64'(vecs[i].rs2));
      check({vecs[i].name, ".rd"},     64'(out_rd),     64'(vecs[i].rd));
      check({vecs[i].name, ".funct3"}, 64'(out_funct3), 64'(f3_exp));
      check({vecs[i].name, ".imm"},    64'(out_imm),    64'(vecs[i].imm));
      check({vecs[i].name, ".alu"},    64'(out_alu_op), 64'(vecs[i].alu));
      check({vecs[i].name, ".strb"},
            64'({out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump}),
            64'(vecs[i].strb));
      check({vecs[i].name, ".illegal"}, 64'(out_illegal), 64'(vecs[i].ill));
      check({vecs[i].name, ".imm64"},   w_out_imm,        imm64_exp);
      check({vecs[i].name, ".ill64"},   64'(w_ill),       64'(vecs[i].ill));
    end
    drive(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("drain.out_valid", 64'(out_valid), 64'd0);

    // stalled consumer: A on output, B in skid, C held at the source
    out_ready = 1'b0;
    drive(1'b1, 32'h002081B3, 32'h200);
    @(negedge clk);
    check("skid.A_valid", 64'(out_valid), 64'd1);
    check("skid.A_pc",    64'(out_pc),    64'h200);
    drive(1'b1, 32'h402081B3, 32'h204);
    @(negedge clk);
    check("skid.A_held",   64'(out_pc),   64'h200);
    check("skid.in_ready", 64'(in_ready), 64'd0);
    drive(1'b1, 32'h0020C233, 32'h208);
    @(negedge clk);
    check("skid.A_held2",   64'(out_pc),   64'h200);
    check("skid.in_ready2", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check("skid.B_valid",  64'(out_valid),  64'd1);
    check("skid.B_pc",     64'(out_pc),     64'h204);
    check("skid.B_alu",    64'(out_alu_op), 64'b0110);
    check("skid.in_ready3", 64'(in_ready),  64'd1);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0);
    check("skid.C_valid", 64'(out_valid),  64'd1);
    check("skid.C_pc",    64'(out_pc),     64'h208);
    check("skid.C_alu",   64'(out_alu_op), 64'b1100);
    @(negedge clk);
    check("skid.empty", 64'(out_valid), 64'd0);

    // flush with output and skid both full
    out_ready = 1'b0;
    drive(1'b1, 32'h002081B3, 32'h280);
    @(negedge clk);
    drive(1'b1, 32'h402081B3, 32'h284);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0);
    check("flush.pre_in_ready", 64'(in_ready), 64'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush.out_valid", 64'(out_valid), 64'd0);
    check("flush.in_ready",  64'(in_ready),  64'd1);
    out_ready = 1'b1;
    drive(1'b1, 32'h00512093, 32'h300);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0);
    check("flush.D_valid", 64'(out_valid), 64'd1);
    check("flush.D_pc",    64'(out_pc),    64'h300);
    @(negedge clk);
    check("flush.D_once", 64'(out_valid), 64'd0);

    // instruction accepted in the same cycle as flush is dropped
    drive(1'b1, 32'h002081B3, 32'h310);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("flush_accept.out_valid", 64'(out_valid), 64'd0);

    // reset mid-stream
    drive(1'b1, 32'h123450B7, 32'h400);
    @(negedge clk);
    check("midrst.pre_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0);
    check("midrst.out_valid", 64'(out_valid), 64'd0);
    check("midrst.in_ready",  64'(in_ready),  64'd0);
    check("midrst.out_pc",    64'(out_pc),    64'(RPC));
    rst = 1'b0;
    @(negedge clk);
    check("midrst.in_ready_after", 64'(in_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
